// File: rtl/tb_mem_arbiter.sv
// Round-robin arbiter sharing one simulation-memory port between NrPorts
// requesters; an in-order routing FIFO steers each response to its issuer.
module tb_mem_arbiter #(
  parameter int unsigned NrPorts        = 2,
  parameter int unsigned AddrWidth      = 48,
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned MaxOutstanding = 8,
  localparam int unsigned StrbWidth     = DataWidth / 8,
  localparam int unsigned IdxWidth      = (NrPorts > 1) ? $clog2(NrPorts) : 1,
  localparam int unsigned CntWidth      = $clog2(MaxOutstanding + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NrPorts-1:0]             in_q_valid_i,
  output logic [NrPorts-1:0]             in_q_ready_o,
  input  logic [NrPorts*AddrWidth-1:0]   in_q_addr_i,
  input  logic [NrPorts-1:0]             in_q_write_i,
  input  logic [NrPorts*DataWidth-1:0]   in_q_data_i,
  input  logic [NrPorts*StrbWidth-1:0]   in_q_strb_i,
  output logic [NrPorts-1:0]             in_p_valid_o,
  input  logic [NrPorts-1:0]             in_p_ready_i,
  output logic [DataWidth-1:0]           in_p_data_o,
  output logic                           in_p_error_o,
  output logic                           mem_q_valid_o,
  input  logic                           mem_q_ready_i,
  output logic [AddrWidth-1:0]           mem_q_addr_o,
  output logic                           mem_q_write_o,
  output logic [DataWidth-1:0]           mem_q_data_o,
  output logic [StrbWidth-1:0]           mem_q_strb_o,
  input  logic                           mem_p_valid_i,
  output logic                           mem_p_ready_o,
  input  logic [DataWidth-1:0]           mem_p_data_i,
  input  logic                           mem_p_error_i,
  output logic [CntWidth-1:0]            outstanding_o
);

  localparam int unsigned PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NrPorts - 1);
  localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(MaxOutstanding - 1);
  localparam logic [CntWidth-1:0] FullCnt = CntWidth'(MaxOutstanding);

  logic [IdxWidth-1:0] rr_q, rr_d;
  logic [IdxWidth-1:0] sel_q, sel_d;
  logic                lock_q, lock_d;
  logic [IdxWidth-1:0] fifo_q [MaxOutstanding];
  logic [IdxWidth-1:0] fifo_d [MaxOutstanding];
  logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;

  logic [IdxWidth-1:0] sel_c, sel_hi, sel_lo, head_c;
  logic                found_hi, found_lo;
  logic                full_c, empty_c, q_hs_c, p_hs_c, head_ready_c;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrWidth'(1);
  endfunction

  assign full_c        = (cnt_q == FullCnt);
  assign empty_c       = (cnt_q == '0);
  assign head_c        = fifo_q[rd_ptr_q];
  assign mem_q_valid_o = rst_ni && (|in_q_valid_i) && !full_c;
  assign q_hs_c        = mem_q_valid_o && mem_q_ready_i;
  assign mem_p_ready_o = head_ready_c && !empty_c;
  assign p_hs_c        = mem_p_valid_i && mem_p_ready_o;
  assign in_p_data_o   = mem_p_data_i;
  assign in_p_error_o  = mem_p_error_i;
  assign outstanding_o = cnt_q;

  // Grant: held selection while locked, else first valid port at or after rr_q (wrapping)
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    sel_hi   = '0;
    sel_lo   = '0;
    for (int unsigned p = 0; p < NrPorts; p++) begin
      if (in_q_valid_i[p]) begin
        if (!found_lo) begin
          found_lo = 1'b1;
          sel_lo   = IdxWidth'(p);
        end
        if (!found_hi && (IdxWidth'(p) >= rr_q)) begin
          found_hi = 1'b1;
          sel_hi   = IdxWidth'(p);
        end
      end
    end
    if (lock_q)        sel_c = sel_q;
    else if (found_hi) sel_c = sel_hi;
    else               sel_c = sel_lo;
  end

  // Request mux: forward the selected port's payload and return ready to it only
  always_comb begin
    in_q_ready_o  = '0;
    mem_q_addr_o  = '0;
    mem_q_write_o = 1'b0;
    mem_q_data_o  = '0;
    mem_q_strb_o  = '0;
    for (int unsigned p = 0; p < NrPorts; p++) begin
      if (IdxWidth'(p) == sel_c) begin
        mem_q_addr_o    = in_q_addr_i[p*AddrWidth +: AddrWidth];
        mem_q_write_o   = in_q_write_i[p];
        mem_q_data_o    = in_q_data_i[p*DataWidth +: DataWidth];
        mem_q_strb_o    = in_q_strb_i[p*StrbWidth +: StrbWidth];
        in_q_ready_o[p] = rst_ni && mem_q_ready_i && !full_c;
      end
    end
  end

  // Response routing to the requester at the FIFO head
  always_comb begin
    in_p_valid_o = '0;
    head_ready_c = 1'b0;
    for (int unsigned p = 0; p < NrPorts; p++) begin
      if (IdxWidth'(p) == head_c) begin
        in_p_valid_o[p] = mem_p_valid_i && !empty_c;
        head_ready_c    = in_p_ready_i[p];
      end
    end
  end

  // Next state: round-robin pointer, stall lock and routing FIFO bookkeeping
  always_comb begin
    rr_d     = rr_q;
    sel_d    = sel_q;
    lock_d   = lock_q;
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (q_hs_c) begin
      rr_d             = (sel_c == LastIdx) ? '0 : sel_c + IdxWidth'(1);
      lock_d           = 1'b0;
      fifo_d[wr_ptr_q] = sel_c;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end else if (mem_q_valid_o) begin
      lock_d = 1'b1;
      sel_d  = sel_c;
    end
    if (p_hs_c) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({q_hs_c, p_hs_c})
      2'b10:   cnt_d = cnt_q + CntWidth'(1);
      2'b01:   cnt_d = cnt_q - CntWidth'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers; reset discards all in-flight routing information
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q     <= '0;
      sel_q    <= '0;
      lock_q   <= 1'b0;
      fifo_q   <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rr_q     <= rr_d;
      sel_q    <= sel_d;
      lock_q   <= lock_d;
      fifo_q   <= fifo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Protocol and integrity checks
  a_payload_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (mem_q_valid_o && !mem_q_ready_i) |=>
      $stable({mem_q_addr_o, mem_q_write_o, mem_q_data_o, mem_q_strb_o}))
    else $error("memory request payload changed while stalled");
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(q_hs_c && full_c))
    else $error("routing FIFO overflow");
  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(p_hs_c && empty_c))
    else $error("routing FIFO underflow");
  a_rsp_without_req: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(mem_p_valid_i && empty_c))
    else $error("memory response with no request outstanding");
  a_ready_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(in_q_ready_o))
    else $error("more than one request ready asserted");

endmodule

// File: doc/tb_mem_arbiter.md
Name: tb_mem_arbiter

Overview:
- Shares one simulation-memory request/response port between NrPorts requesters, e.g. cluster narrow and wide master paths behind protocol adapters.
- Round-robin arbitration on the request channel.
- Tracks outstanding transactions in an in-order routing FIFO, so each memory response returns to the requester that issued it.
- Sits in the test harness between the requesters and the simulation memory model.

Parameters:
- NrPorts, 2, number of requesters (>=1).
- AddrWidth, 48, request address width.
- DataWidth, 64, data width; StrbWidth = DataWidth/8.
- MaxOutstanding, 8, routing FIFO depth (>=1); maximum number of requests in flight.
- IdxWidth, derived, max(1, clog2(NrPorts)).
- CntWidth, derived, clog2(MaxOutstanding+1).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- in_q_valid_i  in  NrPorts  request valid per port.
- in_q_ready_o  out  NrPorts  request accepted per port.
- in_q_addr_i  in  NrPorts*AddrWidth  request address.
- in_q_write_i  in  NrPorts  1 = write, 0 = read.
- in_q_data_i  in  NrPorts*DataWidth  write data.
- in_q_strb_i  in  NrPorts*StrbWidth  write byte strobes.
- in_p_valid_o  out  NrPorts  response valid per port.
- in_p_ready_i  in  NrPorts  response ready per port.
- in_p_data_o  out  DataWidth  response data, broadcast to all ports.
- in_p_error_o  out  1  response error, broadcast to all ports.
- mem_q_valid_o  out  1  memory request valid.
- mem_q_ready_i  in  1  memory request ready.
- mem_q_addr_o  out  AddrWidth  memory address.
- mem_q_write_o  out  1  memory write flag.
- mem_q_data_o  out  DataWidth  memory write data.
- mem_q_strb_o  out  StrbWidth  memory write strobes.
- mem_p_valid_i  in  1  memory response valid.
- mem_p_ready_o  out  1  memory response ready.
- mem_p_data_i  in  DataWidth  memory response data.
- mem_p_error_i  in  1  memory response error.
- outstanding_o  out  CntWidth  number of requests in flight.

Behaviour:
- Clocking and reset: one clock, clk_i; reset is asynchronous and active-low on rst_ni.
- Reset state:
  - rr_q=0, lock_q=0, sel_q=0.
  - FIFO empty, outstanding_o=0.
  - All valid and ready outputs are 0 while in reset.
- Every request produces exactly one memory response; reads and writes alike. Responses return in request order.
- Arbitration (combinational grant):
  - If lock_q=1, sel=sel_q.
  - Otherwise sel = first index i, scanning rr_q, rr_q+1, ... with wrap modulo NrPorts, such that in_q_valid_i[i]=1.
  - full = (outstanding == MaxOutstanding).
  - mem_q_valid_o = |in_q_valid_i && !full.
  - mem_q_* payload = payload of port sel.
  - in_q_ready_o[sel] = mem_q_ready_i && !full; all other bits are 0.
  - Zero added latency: the request passes through in the same cycle.
- Stability: if mem_q_valid_o=1 and mem_q_ready_i=0, set lock_q=1 and sel_q=sel. The lock clears on the memory handshake. Requesters must hold valid once asserted, so the payload stays stable until accepted.
- On memory request handshake (mem_q_valid_o && mem_q_ready_i):
  - Push sel into the FIFO.
  - rr_q <= (sel+1) mod NrPorts.
  - lock_q <= 0.
- Full: new requests stall while outstanding == MaxOutstanding, even if a pop happens in the same cycle. There is no same-cycle bypass.
- Response routing:
  - head = FIFO head index.
  - in_p_valid_o[head] = mem_p_valid_i && !empty; all other bits are 0.
  - mem_p_ready_o = in_p_ready_i[head] && !empty.
  - Data and error pass through combinationally.
  - Pop on memory response handshake.
- Simultaneous push and pop: outstanding is unchanged; the FIFO pointers both advance, wrapping modulo MaxOutstanding.
- mem_p_valid_i while the FIFO is empty is a protocol error:
  - mem_p_ready_o stays 0 and nothing is routed.
  - A simulation assertion fires.
- Reset mid-operation: all state returns to the reset state immediately and in-flight routing information is discarded. Memory and requesters must be reset together.
- NrPorts=1: the arbiter degenerates to a pass-through with outstanding tracking; rr_q stays 0.
- Assertions:
  - Payload stable while valid && !ready.
  - No FIFO overflow or underflow.
  - in_q_ready_o is one-hot or zero.

Test Plan:
- Single read: port0 addr=0x1000, memory ready, response data=0xDEAD_BEEF one cycle later -> in_q_ready_o=2'b01 in the request cycle; in_p_valid_o=2'b01 with data 0xDEADBEEF; outstanding_o goes 0->1->0.
- Fairness: both ports valid continuously, memory always ready -> grants alternate 0,1,0,1; responses routed 0,1,0,1 in order.
- Backpressure lock: port1 valid, mem_q_ready_i=0 for 3 cycles, port0 raises valid in cycle 2 -> sel stays 1 and payload stays stable; port1 accepted in cycle 4, then port0 accepted.
- Full: MaxOutstanding=2, 3 requests, no responses -> third request stalls with mem_q_valid_o=0 and outstanding_o=2; after one response pop the third request is accepted on the next cycle.
- Response backpressure: head=port0, in_p_ready_i[0]=0 for 2 cycles -> mem_p_ready_o=0 and no pop; the pop happens when ready rises. Port1's in_p_ready_i has no effect.
- Reset mid-flight: 3 requests outstanding, assert rst_ni=0 -> outstanding_o=0 and all valid outputs 0 immediately; after release, a fresh port1 request is granted first with rr_q=0 scan.
